mac_datapath: RTL

//  Dual-lane multiply-accumulate datapath driven by the matrix controller's mult/sum/clear/write strobes.

---
 rtl/mac_datapath.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mac_datapath.sv
// Dual-lane multiply-accumulate datapath. The controller strobes are delayed to meet
// the ROM data for their address. Each lane accumulates products and a bias term,
// then presents a saturated result to the result RAM.
module mac_datapath #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned ACC_WIDTH    = 40,
  parameter int unsigned RESULT_WIDTH = 32,
  parameter int unsigned ROM_LATENCY  = 1,
  parameter int unsigned RESULT_COUNT = 64
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    mult,
  input  logic                    sum,
  input  logic                    clear,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   romA_dataA,
  input  logic [DATA_WIDTH-1:0]   romA_dataB,
  input  logic [DATA_WIDTH-1:0]   romB_dataA,
  input  logic [DATA_WIDTH-1:0]   romB_dataB,
  input  logic [DATA_WIDTH-1:0]   romC_dataA,
  input  logic [DATA_WIDTH-1:0]   romC_dataB,
  output logic [RESULT_WIDTH-1:0] result_dataA,
  output logic [RESULT_WIDTH-1:0] result_dataB,
  output logic                    result_weA,
  output logic                    result_weB,
  output logic                    end_operation,
  output logic                    overflow
);

  localparam int unsigned CntW = $clog2(RESULT_COUNT + 1);

  // Control bit positions within each delay-line stage.
  localparam int unsigned BitWrite = 0;
  localparam int unsigned BitMult  = 1;
  localparam int unsigned BitSum   = 2;
  localparam int unsigned BitClear = 3;

  // Saturation bounds, sign-extended to accumulator width.
  localparam logic [ACC_WIDTH-1:0] SatMax =
    {{(ACC_WIDTH-RESULT_WIDTH+1){1'b0}}, {(RESULT_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SatMin =
    {{(ACC_WIDTH-RESULT_WIDTH+1){1'b1}}, {(RESULT_WIDTH-1){1'b0}}};

  logic [3:0]            ctrl_q [ROM_LATENCY];
  logic [3:0]            ctrl_d;
  logic [ACC_WIDTH-1:0]  acc_a_q, acc_a_d;
  logic [ACC_WIDTH-1:0]  acc_b_q, acc_b_d;
  logic [CntW-1:0]       write_cnt_q, write_cnt_d;
  logic                  overflow_q, overflow_d;
  logic                  sat_a, sat_b;

  // Next accumulator value; clear beats sum beats mult.
  function automatic logic [ACC_WIDTH-1:0] acc_next(
    input logic [ACC_WIDTH-1:0]  acc,
    input logic [3:0]            ctrl,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b,
    input logic [DATA_WIDTH-1:0] c
  );
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    prod_ext;
    logic signed [ACC_WIDTH-1:0]    c_ext;
    prod     = $signed(a) * $signed(b);
    prod_ext = ACC_WIDTH'(prod);
    c_ext    = ACC_WIDTH'($signed(c));
    if (ctrl[BitClear])     acc_next = '0;
    else if (ctrl[BitSum])  acc_next = acc + c_ext;
    else if (ctrl[BitMult]) acc_next = acc + prod_ext;
    else                    acc_next = acc;
  endfunction

  // Clamp the accumulator into the result range; flag when clamping occurred.
  function automatic logic [RESULT_WIDTH:0] saturate(input logic [ACC_WIDTH-1:0] acc);
    if ($signed(acc) > $signed(SatMax))      saturate = {1'b1, SatMax[RESULT_WIDTH-1:0]};
    else if ($signed(acc) < $signed(SatMin)) saturate = {1'b1, SatMin[RESULT_WIDTH-1:0]};
    else                                     saturate = {1'b0, acc[RESULT_WIDTH-1:0]};
  endfunction

  assign ctrl_d = ctrl_q[ROM_LATENCY-1];

  // Strobe delay line aligning controller strobes with ROM data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < ROM_LATENCY; i++) ctrl_q[i] <= '0;
    end else begin
      ctrl_q[0] <= {clear, sum, mult, write};
      for (int unsigned i = 1; i < ROM_LATENCY; i++) ctrl_q[i] <= ctrl_q[i-1];
    end
  end

  // Per-lane accumulator update and result saturation.
  always_comb begin
    acc_a_d = acc_next(acc_a_q, ctrl_d, romA_dataA, romB_dataA, romC_dataA);
    acc_b_d = acc_next(acc_b_q, ctrl_d, romA_dataB, romB_dataB, romC_dataB);
    {sat_a, result_dataA} = saturate(acc_a_q);
    {sat_b, result_dataB} = saturate(acc_b_q);
  end

  // Write counter saturates at the final count; overflow is sticky.
  always_comb begin
    write_cnt_d = write_cnt_q;
    if (write && (write_cnt_q < CntW'(RESULT_COUNT))) write_cnt_d = write_cnt_q + 1'b1;
    overflow_d = overflow_q | (ctrl_d[BitWrite] & (sat_a | sat_b));
  end

  // State registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_a_q     <= '0;
      acc_b_q     <= '0;
      write_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      acc_a_q     <= acc_a_d;
      acc_b_q     <= acc_b_d;
      write_cnt_q <= write_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  assign result_weA = ctrl_d[BitWrite];
  assign result_weB = ctrl_d[BitWrite];
  assign overflow   = overflow_q;

  // Uses the undelayed strobe so the controller sees it during its final write.
  // Gated by reset so small RESULT_COUNT values still read 0 while in reset.
  assign end_operation = reset_n && (write_cnt_q >= CntW'(RESULT_COUNT - 1)) &&
                         (write || (write_cnt_q == CntW'(RESULT_COUNT)));

endmodule
